game_timer: RTL and testbench

- Elapsed-time source for the Tetris display path; drives the gameClock[3] BCD digits that the pixel colour mapper renders as "M:SS" to the left of the board.
- Clocked by frame_clk (one pulse per video frame, nominally 60 Hz); divides frames into seconds and keeps a saturating BCD minute/second count.
- Accepts start/pause/clear commands from game control logic.
- Reports running status, a per-second tick and a terminal time_up flag.

---
 rtl/game_timer.sv | 183 ++++++++++++++++++
 tb/tb_game_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// game_timer: frame-driven M:SS game clock for the display path.
// Divides frame_clk into seconds and keeps a saturating BCD minute/second
// count with start/pause/clear control, a per-second tick and a time_up flag.
// Build option: define GAME_TIMER_COUNTDOWN_EN to count down from
// PRESET_MIN:PRESET_SEC to 0:00 instead of counting up to MAX_MIN:59.
module game_timer #(
   parameter int FRAMES_PER_SEC = 60,
   parameter int MAX_MIN        = 9,
   parameter int PRESET_MIN     = 2,
   parameter int PRESET_SEC     = 0
) (
   input  logic       frame_clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [3:0] gameClock [3],
   output logic       running,
   output logic       sec_tick,
   output logic       time_up
);

   localparam int CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [CW-1:0] FC_LAST = CW'(FRAMES_PER_SEC - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

`ifdef GAME_TIMER_COUNTDOWN_EN
   localparam bit COUNT_DOWN = 1'b1;
`else
   localparam bit COUNT_DOWN = 1'b0;
`endif

   // Value the digits take after reset or clear, in whole seconds.
   localparam int LOAD_SECS = COUNT_DOWN ? (PRESET_MIN * 60 + PRESET_SEC) : 0;
   localparam logic [3:0] LOAD_MIN  = 4'(LOAD_SECS / 60);
   localparam logic [3:0] LOAD_TEN  = 4'((LOAD_SECS % 60) / 10);
   localparam logic [3:0] LOAD_UNIT = 4'(LOAD_SECS % 10);
   // A countdown preset of 0:00 has nothing to count, so start ends the game at once.
   localparam bit LOAD_ZERO = COUNT_DOWN && (LOAD_SECS == 0);

   logic [1:0]    r_state;
   logic [CW-1:0] r_frame_cnt;
   logic [3:0]    r_digit [3];
   logic          r_tick;

   logic [1:0]    w_state_next;
   logic [CW-1:0] w_fc_next;
   logic [3:0]    w_digit_next [3];
   logic          w_tick_next;

   // Digits after a one-second step, and whether that step ends the game.
   logic [3:0]    w_adv [3];
   logic          w_adv_last;

`ifdef GAME_TIMER_COUNTDOWN_EN
   // One-second BCD decrement with borrow; reaching 0:00 is terminal.
   always_comb begin
      w_adv[0]   = r_digit[0];
      w_adv[1]   = r_digit[1];
      w_adv[2]   = r_digit[2];
      w_adv_last = (r_digit[2] == 4'd0) && (r_digit[1] == 4'd0) && (r_digit[0] == 4'd1);
      if (r_digit[0] != 4'd0) begin
         w_adv[0] = r_digit[0] - 4'd1;
      end else begin
         w_adv[0] = 4'd9;
         if (r_digit[1] != 4'd0) begin
            w_adv[1] = r_digit[1] - 4'd1;
         end else begin
            w_adv[1] = 4'd5;
            w_adv[2] = r_digit[2] - 4'd1;
         end
      end
   end
`else
   localparam logic [3:0] MAX_MIN_D = 4'(MAX_MIN);

   // One-second BCD increment with carry; at MAX_MIN:59 the digits saturate.
   always_comb begin
      w_adv[0]   = r_digit[0];
      w_adv[1]   = r_digit[1];
      w_adv[2]   = r_digit[2];
      w_adv_last = (r_digit[2] == MAX_MIN_D) && (r_digit[1] == 4'd5) && (r_digit[0] == 4'd9);
      if (!w_adv_last) begin
         if (r_digit[0] != 4'd9) begin
            w_adv[0] = r_digit[0] + 4'd1;
         end else begin
            w_adv[0] = 4'd0;
            if (r_digit[1] != 4'd5) begin
               w_adv[1] = r_digit[1] + 4'd1;
            end else begin
               w_adv[1] = 4'd0;
               w_adv[2] = r_digit[2] + 4'd1;
            end
         end
      end
   end
`endif

   // Next-state decode; clear beats pause, pause beats start.
   always_comb begin
      w_state_next = r_state;
      w_fc_next    = r_frame_cnt;
      w_digit_next = r_digit;
      w_tick_next  = 1'b0;
      if (clear) begin
         w_state_next    = S_IDLE;
         w_fc_next       = '0;
         w_digit_next[0] = LOAD_UNIT;
         w_digit_next[1] = LOAD_TEN;
         w_digit_next[2] = LOAD_MIN;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_fc_next = '0;
                  if (LOAD_ZERO) begin
                     w_state_next = S_DONE;
                  end else if (pause) begin
                     w_state_next = S_PAUSE;
                  end else begin
                     w_state_next = S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (pause) begin
                  w_state_next = S_PAUSE;
               end else if (r_frame_cnt == FC_LAST) begin
                  w_fc_next    = '0;
                  w_digit_next = w_adv;
                  w_tick_next  = 1'b1;
                  if (w_adv_last) begin
                     w_state_next = S_DONE;
                  end
               end else begin
                  w_fc_next = r_frame_cnt + CW'(1);
               end
            end
            S_PAUSE: begin
               // Resume without counting this edge so the held phase is kept.
               if (!pause) begin
                  w_state_next = S_RUN;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State, frame divider, digits and tick registers.
   always_ff @(posedge frame_clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_frame_cnt <= '0;
         r_digit[0]  <= LOAD_UNIT;
         r_digit[1]  <= LOAD_TEN;
         r_digit[2]  <= LOAD_MIN;
         r_tick      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_frame_cnt <= w_fc_next;
         r_digit     <= w_digit_next;
         r_tick      <= w_tick_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_digit_out
         assign gameClock[gi] = r_digit[gi];
      end
   endgenerate

   assign running  = (r_state == S_RUN);
   assign time_up  = (r_state == S_DONE);
   assign sec_tick = r_tick;

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed phases plus random command segments for game_timer,
// checked every frame against a seconds-level behavioural model.
// Honours GAME_TIMER_COUNTDOWN_EN when the design is built with it.
module tb_game_timer;

   localparam int F    = 60;
   localparam int MAXM = 9;
   localparam int PM   = 2;
   localparam int PS   = 0;
   localparam int TERM = MAXM * 60 + 59;

`ifdef GAME_TIMER_COUNTDOWN_EN
   localparam bit CD    = 1'b1;
   localparam int LOAD  = PM * 60 + PS;
   localparam int T_A   = 60;
   localparam int T_RST = 35;
   localparam int T_END = 0;
`else
   localparam bit CD    = 1'b0;
   localparam int LOAD  = 0;
   localparam int T_A   = 59;
   localparam int T_RST = 207;
   localparam int T_END = TERM;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       frame_clk = 1'b0;
   logic       reset;
   logic       start;
   logic       pause;
   logic       clear;
   logic [3:0] gameClock [3];
   logic       running;
   logic       sec_tick;
   logic       time_up;

   game_timer #(
      .FRAMES_PER_SEC(F),
      .MAX_MIN(MAXM),
      .PRESET_MIN(PM),
      .PRESET_SEC(PS)
   ) dut (
      .frame_clk(frame_clk),
      .reset(reset),
      .start(start),
      .pause(pause),
      .clear(clear),
      .gameClock(gameClock),
      .running(running),
      .sec_tick(sec_tick),
      .time_up(time_up)
   );

   always #5 frame_clk = ~frame_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: elapsed (or remaining) whole seconds plus frame phase.
   int m_mode;
   int m_fc;
   int m_secs;
   bit m_tick;

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
         if (errors >= 40) finish_run();
      end
   endtask

   function automatic logic [11:0] to_bcd(input int s);
      return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   function automatic logic [11:0] dut_bcd();
      return {gameClock[2], gameClock[1], gameClock[0]};
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE;
      m_fc   = 0;
      m_secs = LOAD;
      m_tick = 1'b0;
   endtask

   task automatic model_edge(input bit s, input bit p, input bit c);
      m_tick = 1'b0;
      if (c) begin
         m_mode = M_IDLE;
         m_fc   = 0;
         m_secs = LOAD;
      end else begin
         case (m_mode)
            M_IDLE: if (s) begin
               m_fc = 0;
               if (CD && LOAD == 0) m_mode = M_DONE;
               else m_mode = p ? M_PAUSE : M_RUN;
            end
            M_RUN: begin
               if (p) begin
                  m_mode = M_PAUSE;
               end else if (m_fc == F - 1) begin
                  m_fc   = 0;
                  m_tick = 1'b1;
                  if (CD) begin
                     m_secs = m_secs - 1;
                     if (m_secs == 0) m_mode = M_DONE;
                  end else if (m_secs == TERM) begin
                     m_mode = M_DONE;
                  end else begin
                     m_secs = m_secs + 1;
                  end
               end else begin
                  m_fc = m_fc + 1;
               end
            end
            M_PAUSE: if (!p) m_mode = M_RUN;
            default: begin
            end
         endcase
      end
   endtask

   task automatic compare();
      check("digits", dut_bcd(), to_bcd(m_secs));
      check("running", running, m_mode == M_RUN);
      check("sec_tick", sec_tick, m_tick);
      check("time_up", time_up, m_mode == M_DONE);
   endtask

   // One frame: drive inputs, take the edge, advance the model, compare after the edge.
   task automatic cycle(input bit s, input bit p, input bit c);
      start = s;
      pause = p;
      clear = c;
      @(posedge frame_clk);
      model_edge(s, p, c);
      #1 compare();
   endtask

   task automatic run_until(input int target, input int limit, input string tag);
      int n = 0;
      while (dut_bcd() != to_bcd(target) && n < limit) begin
         cycle(1'b0, 1'b0, 1'b0);
         n++;
      end
      check(tag, dut_bcd(), to_bcd(target));
   endtask

   // Called just after cycle(): lands between edges, checks, then releases.
   task automatic async_reset();
      #3 reset = 1'b1;
      #1 model_reset();
      compare();
      #1 reset = 1'b0;
   endtask

   initial begin
      int n;
      int ticks;
      logic [11:0] d0;

      start = 1'b0;
      pause = 1'b0;
      clear = 1'b0;
      reset = 1'b1;
      model_reset();
      #12;
      compare();
      reset = 1'b0;
      $display("txn reset values checked");

      cycle(1'b1, 1'b0, 1'b0);
      repeat (F) cycle(1'b0, 1'b0, 1'b0);
      check("first_sec", dut_bcd(), to_bcd(CD ? LOAD - 1 : 1));
      $display("txn start and first second -> %h", dut_bcd());

      run_until(T_A, 45000, "reach_a");
      repeat (30) cycle(1'b0, 1'b0, 1'b0);
      repeat (100) cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      d0 = dut_bcd();
      n  = 0;
      while (dut_bcd() == d0 && n < 200) begin
         cycle(1'b0, 1'b0, 1'b0);
         n++;
      end
      check("resume_gap", n, 30);
      check("after_pause", dut_bcd(), to_bcd(CD ? T_A - 1 : T_A + 1));
      $display("txn pause 100 frames mid-second, change %0d frames after release", n);

      run_until(T_RST, 45000, "reach_rst");
      repeat (20) cycle(1'b0, 1'b0, 1'b0);
      async_reset();
      check("rst_digits", dut_bcd(), to_bcd(LOAD));
      check("rst_running", running, 1'b0);
      repeat (5) cycle(1'b0, 1'b0, 1'b0);
      $display("txn async reset mid-run");

      cycle(1'b1, 1'b0, 1'b0);
      run_until(T_END, 45000, "reach_end");
      ticks = 0;
      repeat (130) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (sec_tick === 1'b1) ticks++;
      end
      check("end_ticks", ticks, CD ? 0 : 1);
      repeat (5) cycle(1'b1, 1'b1, 1'b0);
      check("done_tup", time_up, 1'b1);
      check("done_digits", dut_bcd(), to_bcd(T_END));
      $display("txn run to terminal -> %h time_up=%0d", dut_bcd(), time_up);

      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      repeat (10) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      check("clr_running", running, 1'b0);
      check("clr_digits", dut_bcd(), to_bcd(LOAD));
      cycle(1'b1, 1'b1, 1'b0);
      repeat (80) cycle(1'b0, 1'b1, 1'b0);
      check("idle_pause_digits", dut_bcd(), to_bcd(LOAD));
      repeat (70) cycle(1'b0, 1'b0, 1'b0);
      $display("txn clear+pause in run, start+pause in idle -> %h", dut_bcd());

      for (int k = 0; k < 60; k++) begin
         bit s;
         bit p;
         bit c;
         int len;
         len = $urandom_range(1, 90);
         s   = ($urandom_range(0, 99) < 35);
         p   = ($urandom_range(0, 99) < 25);
         c   = ($urandom_range(0, 99) < 8);
         $display("txn seg %0d start=%0d pause=%0d clear=%0d len=%0d", k, s, p, c, len);
         for (int j = 0; j < len; j++) cycle(s && j == 0, p, c && j == 0);
         if ($urandom_range(0, 19) == 0) async_reset();
      end

      finish_run();
   end

endmodule
